// File: rtl/mdu.sv
// mdu: multiply/divide unit for the MIPS E stage; owns HI/LO and reports busy while an op is in flight.
// Define MDU_MADD_EN to accept madd/maddu (ops 7/8) accumulating into {HI,LO}.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] mdu_out
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_a, r_b;
    logic [3:0]  r_op;

    logic        w_isMultOp, w_isDivOp, w_launch, w_commit, w_divSigned;
    logic [63:0] w_prodS, w_prodU;
    logic [31:0] w_dvd, w_dvs, w_q, w_r, w_quo, w_rem;
    logic [31:0] w_resHi, w_resLo;

    always_comb begin
        w_isMultOp = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
        w_isMultOp = w_isMultOp || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
`endif
        w_isDivOp = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
        w_launch  = start && (r_state == IDLE) && (w_isMultOp || w_isDivOp);
        w_commit  = (r_state == RUN) && (r_cnt == 8'd1);
    end

    // Signed division works on magnitudes so the INT_MIN / -1 case wraps naturally.
    always_comb begin
        w_prodS     = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_prodU     = {32'd0, r_a} * {32'd0, r_b};
        w_divSigned = (r_op == OP_DIV);
        w_dvd       = (w_divSigned && r_a[31]) ? (32'd0 - r_a) : r_a;
        w_dvs       = (w_divSigned && r_b[31]) ? (32'd0 - r_b) : r_b;
        w_q         = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
        w_r         = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
        w_quo       = (w_divSigned && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q) : w_q;
        w_rem       = (w_divSigned && r_a[31]) ? (32'd0 - w_r) : w_r;
    end

    always_comb begin
        w_resHi = r_hi;
        w_resLo = r_lo;
        case (r_op)
            OP_MULT:  {w_resHi, w_resLo} = w_prodS;
            OP_MULTU: {w_resHi, w_resLo} = w_prodU;
            OP_DIV, OP_DIVU: begin
                if (r_b != 32'd0) begin
                    w_resHi = w_rem;
                    w_resLo = w_quo;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodS;
            OP_MADDU: {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodU;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_launch) w_nextState = RUN;
            RUN:  if (w_commit) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // A start seen while RUN is deliberately dropped; only IDLE accepts ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_cnt <= 8'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_op  <= 4'd0;
        end else if (r_state == IDLE) begin
            if (w_launch) begin
                r_a   <= A;
                r_b   <= B;
                r_op  <= mdu_op;
                r_cnt <= w_isMultOp ? MULT_CNT : DIV_CNT;
            end else if (start && (mdu_op == OP_MTHI)) begin
                r_hi <= A;
            end else if (start && (mdu_op == OP_MTLO)) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 8'd1;
            if (w_commit) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign mdu_out = rd_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; stimulus pushes expected HI/LO/busy-length, a monitor checks.
// Build with MDU_MADD_EN defined to exercise madd/maddu expectations.
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset, start, rdSel, busy;
    logic [3:0]  mduOp;
    logic [31:0] opA, opB, mduOut;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mduOp),
        .A(opA), .B(opB), .rd_sel(rdSel), .busy(busy), .mdu_out(mduOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          expBusy;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } exp_t;

    exp_t        scoreQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] modelHi    = 32'd0;
    logic [31:0] modelLo    = 32'd0;

    // Architectural reference: what HI/LO become and how long busy lasts.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busyN);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        busyN = 0;
        case (op)
            4'd1: begin acc = 64'(sa * sb); {modelHi, modelLo} = acc; busyN = MULT_N; end
            4'd2: begin acc = 64'(ua * ub); {modelHi, modelLo} = acc; busyN = MULT_N; end
            4'd3: begin
                busyN = DIV_N;
                if (b != 32'd0) begin
                    modelLo = 32'(sa / sb);
                    modelHi = 32'(sa % sb);
                end
            end
            4'd4: begin
                busyN = DIV_N;
                if (b != 32'd0) begin
                    modelLo = 32'(ua / ub);
                    modelHi = 32'(ua % ub);
                end
            end
            4'd5: modelHi = a;
            4'd6: modelLo = a;
`ifdef MDU_MADD_EN
            4'd7: begin acc = {modelHi, modelLo} + 64'(sa * sb); {modelHi, modelLo} = acc; busyN = MULT_N; end
            4'd8: begin acc = {modelHi, modelLo} + 64'(ua * ub); {modelHi, modelLo} = acc; busyN = MULT_N; end
`endif
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input string what,
                               input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, what, got, want);
        end
    endtask

    task automatic finishRun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic waitIdle();
        int waited = 0;
        while ((scoreQ.size() != 0) || busy) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 100) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL waitIdle: timeout with %0d pending, busy=%0b", scoreQ.size(), busy);
                finishRun();
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
        int   n;
        exp_t e;
        waitIdle();
        modelOp(op, a, b, n);
        e.name = name; e.expBusy = n; e.expHi = modelHi; e.expLo = modelLo;
        scoreQ.push_back(e);
        mduOp = op; opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mduOp = 4'd0;
    endtask

    // Monitor: counts busy cycles after the issue edge, then reads HI and LO.
    initial begin : monitor
        exp_t        e;
        int          busyCnt;
        logic [31:0] gotHi, gotLo;
        rdSel = 1'b0;
        forever begin
            @(negedge clk);
            if (scoreQ.size() != 0) begin
                e = scoreQ[0];
                busyCnt = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (!busy) break;
                    busyCnt++;
                end
                rdSel = 1'b1;
                #1 gotHi = mduOut;
                rdSel = 1'b0;
                #1 gotLo = mduOut;
                checkOutput(e.name, "busyCycles", 32'(busyCnt), 32'(e.expBusy));
                checkOutput(e.name, "HI", gotHi, e.expHi);
                checkOutput(e.name, "LO", gotLo, e.expLo);
                void'(scoreQ.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (start && busy) begin
            mismatched++;
            $display("[TB] FAIL protocol: start issued while busy, op=%0d", mduOp);
        end
    end

    initial begin : stimulus
        exp_t        e;
        logic [3:0]  rOp;
        logic [31:0] rA, rB;
        reset = 1'b1; start = 1'b0; mduOp = 4'd0; opA = 32'd0; opB = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(4'd0, 32'h0, 32'h0, "resetState");
        applyStimulus(4'd1, 32'hFFFFFFFF, 32'h00000002, "multNeg");
        applyStimulus(4'd2, 32'hFFFFFFFF, 32'h00000002, "multu");
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'h00000002, "divNeg");
        applyStimulus(4'd4, 32'h00000007, 32'h00000000, "divuByZero");
        applyStimulus(4'd3, 32'h12345678, 32'h00000000, "divByZero");
        applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, "divOverflow");
        applyStimulus(4'd3, 32'h00000007, 32'hFFFFFFFE, "divPosByNeg");
        applyStimulus(4'd5, 32'h12345678, 32'h0, "mthi");
        applyStimulus(4'd6, 32'h9ABCDEF0, 32'h0, "mtlo");
        applyStimulus(4'd9, 32'hFFFFFFFF, 32'h1, "invalidOp");
        applyStimulus(4'd5, 32'h00000000, 32'h0, "maddPrepHi");
        applyStimulus(4'd6, 32'hFFFFFFFF, 32'h0, "maddPrepLo");
        applyStimulus(4'd8, 32'h00000001, 32'h00000001, "maddu");
        applyStimulus(4'd7, 32'hFFFFFFFD, 32'h00000004, "madd");

        applyStimulus(4'd5, 32'hDEADBEEF, 32'h0, "preResetHi");
        waitIdle();
        e.name = "resetMidDiv"; e.expBusy = 4; e.expHi = 32'd0; e.expLo = 32'd0;
        scoreQ.push_back(e);
        mduOp = 4'd3; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; mduOp = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        waitIdle();
        repeat (12) @(posedge clk);
        #1;
        applyStimulus(4'd0, 32'h0, 32'h0, "noLateCommit");

        for (int i = 0; i < 40; i++) begin
            rOp = 4'($urandom_range(0, 9));
            rA  = $urandom;
            rB  = $urandom;
            if ($urandom_range(0, 7) == 0) rB = 32'd0;
            if ($urandom_range(0, 15) == 0) begin rA = 32'h80000000; rB = 32'hFFFFFFFF; end
            applyStimulus(rOp, rA, rB, $sformatf("rand%0d_op%0d", i, rOp));
        end

        waitIdle();
        repeat (2) @(posedge clk);
        finishRun();
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It is the responder side of the D-stage freeze handshake: it owns the HI/LO registers, runs multi-cycle mult/div operations, and reports `busy` so the hazard unit can freeze any HI/LO-touching instruction held in D. Results are read combinationally for mfhi/mflo and travel down the pipeline like an ALU result.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/maddu when compiled in).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk  input  1  clock; all state changes on the rising edge`
- `reset  input  1  synchronous, active-high; clears all state`
- `start  input  1  one-cycle pulse: launch or write op named by mdu_op`
- `mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu`
- `A  input  32  E-stage forwarded rs value (E_rs_true)`
- `B  input  32  E-stage forwarded rt value (E_rt_true)`
- `rd_sel  input  1  0 selects LO, 1 selects HI on mdu_out`
- `busy  output  1  operation in flight; reset 0`
- `mdu_out  output  32  combinational HI or LO per rd_sel; reset 0`

## Operation
- States: IDLE, RUN. Reset: IDLE, HI=0, LO=0, cnt=0, busy=0.
- IDLE, start with op 1-4/7/8: latch A, B, op; load cnt with MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, start with op 5 (mthi): HI<=A at that edge; op 6 (mtlo): LO<=A. Stay IDLE, busy stays 0.
- RUN: cnt decrements each edge; on the edge where cnt==1, commit result to HI/LO, go IDLE.
- mult: {HI,LO} <= signed(A)*signed(B), 64-bit. multu: unsigned 64-bit product.
- div: LO <= signed quotient truncated toward zero, HI <= remainder with sign of dividend. divu: unsigned.
- B==0 on div/divu: operation still occupies DIV_CYCLES busy cycles; HI and LO unchanged at commit.
- Overflow case 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
- start, mdu_op 0, or mdu_op > 8 while IDLE: no state change.
- start while RUN: ignored entirely (hazard unit must never allow it; bench flags as protocol error).
- Hazard contract: the hazard unit freezes D when D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo (and madd/maddu) and (E-stage start | busy) is 1.
- mdu_out reads the architectural HI/LO registers only; no bypass of in-flight results.

## Timing
- start sampled at edge t: busy=1 from cycle t+1 through t+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO hold new value and busy=0 from cycle t+N+1.
- mthi/mtlo: new value visible on mdu_out the cycle after the start edge.
- Back-to-back: new start accepted in the first cycle busy=0.
- Reset asserted mid-RUN: at that edge, state IDLE, busy=0, HI=LO=0; pending result discarded. Reset overrides a simultaneous start.
- Output latency of mdu_out: zero (pure mux of registers).

## Configuration
- `MDU_MADD_EN` defined: ops 7 (madd) and 8 (maddu) accepted; {HI,LO} <= {HI,LO} + product (signed/unsigned, 64-bit wrap), MULT_CYCLES latency, accumulator sampled at commit edge.
- Not defined: ops 7 and 8 treated as none (no busy, no state change); hazard unit excludes madd/maddu from its HI/LO check.

## Test plan
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> busy 1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=0 -> 10 busy cycles, HI/LO unchanged.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 -> rd_sel=1 reads 0x12345678, rd_sel=0 reads 0x9ABCDEF0, busy never 1.
- div launched, reset asserted at busy cycle 4 -> busy=0, HI=LO=0 next cycle, no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1 B=1 -> HI=0x00000001, LO=0x00000000; without macro, same stimulus leaves HI/LO unchanged and busy 0.
